audio_out: RTL and testbench

- I2S master transmitter toward the codec DAC, mirroring the ADC-side capture path.
- Runs on the codec master clock and derives BCLK and DACLRCK from it.
- Accepts processed stereo samples from the distortion chain over a valid/ready handshake into a one-frame holding buffer.
- Serialises each frame MSB-first in standard I2S format (MSB one BCLK after the LRCLK edge).

---
 rtl/audio_out.sv | 158 +++++++++++++++
 tb/tb_audio_out.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_out.sv
// audio_out: I2S master transmitter toward the codec DAC.
// Derives BCLK and DACLRCK from MCLK and serialises one stereo frame per LRCLK period.
//
// Ports:
//   MCLK         sole clock, rising edge
//   RESET_N      synchronous active-low reset
//   left_in      signed left sample
//   right_in     signed right sample
//   sample_valid left_in/right_in hold a stereo pair
//   sample_ready holding buffer empty
//   BCLK         bit clock to codec
//   DACLRCK      0 = left slot, 1 = right slot
//   DACDAT       serial data, MSB one BCLK after LRCLK edge
//   underrun     one-cycle pulse when a frame starts with no buffered pair
module audio_out #(
   parameter int BCLK_DIV  = 4,
   parameter int SLOT_BITS = 32,
   parameter int DATA_W    = 16
) (
   input  logic                     MCLK,
   input  logic                     RESET_N,
   input  logic signed [DATA_W-1:0] left_in,
   input  logic signed [DATA_W-1:0] right_in,
   input  logic                     sample_valid,
   output logic                     sample_ready,
   output logic                     BCLK,
   output logic                     DACLRCK,
   output logic                     DACDAT,
   output logic                     underrun
);

   localparam int DW = $clog2(BCLK_DIV);
   localparam int BW = $clog2(2 * SLOT_BITS);

   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
   localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);
   localparam logic [BW-1:0] LAST_K   = BW'(DATA_W);

   logic [DW-1:0]     div_q, div_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              bclk_q, bclk_d;
   logic              lrck_q, lrck_d;
   logic              dat_q, dat_d;
   logic              und_q, und_d;
   logic              rdy_q, rdy_d;
   logic              full_q, full_d;
   logic [DATA_W-1:0] buf_l_q, buf_l_d;
   logic [DATA_W-1:0] buf_r_q, buf_r_d;
   logic [DATA_W-1:0] sh_l_q, sh_l_d;
   logic [DATA_W-1:0] sh_r_q, sh_r_d;

   logic              fall;
   logic              accept;
   logic [BW-1:0]     k;

   always_comb begin
      div_d   = div_q;
      bit_d   = bit_q;
      bclk_d  = bclk_q;
      lrck_d  = lrck_q;
      dat_d   = dat_q;
      und_d   = 1'b0;
      full_d  = full_q;
      buf_l_d = buf_l_q;
      buf_r_d = buf_r_q;
      sh_l_d  = sh_l_q;
      sh_r_d  = sh_r_q;
      k       = '0;

      fall   = (div_q == DIV_LAST);
      accept = sample_valid && rdy_q;

      div_d = fall ? '0 : div_q + DW'(1);
      if (div_d == DIV_HALF) begin
         bclk_d = 1'b1;
      end

      if (accept) begin
         buf_l_d = left_in;
         buf_r_d = right_in;
         full_d  = 1'b1;
      end

      if (fall) begin
         bclk_d = 1'b0;
         bit_d  = (bit_q == BIT_LAST) ? '0 : bit_q + BW'(1);
         lrck_d = (bit_d >= SLOT);
         k      = lrck_d ? bit_d - SLOT : bit_d;

         // Frame load looks at the buffer state before this cycle's
         // accept, so a coincident push waits for the next frame.
         if (bit_d == '0) begin
            if (full_q) begin
               sh_l_d = buf_l_q;
               sh_r_d = buf_r_q;
               full_d = 1'b0;
            end else begin
               sh_l_d = '0;
               sh_r_d = '0;
               und_d  = 1'b1;
            end
         end

         if (k >= BW'(1) && k <= LAST_K) begin
            if (lrck_d) begin
               dat_d  = sh_r_q[DATA_W-1];
               sh_r_d = sh_r_q << 1;
            end else begin
               dat_d  = sh_l_q[DATA_W-1];
               sh_l_d = sh_l_q << 1;
            end
         end else begin
            dat_d = 1'b0;
         end
      end

      rdy_d = !full_d;
   end

   always_ff @(posedge MCLK) begin
      if (!RESET_N) begin
         div_q   <= '0;
         bit_q   <= BIT_LAST;
         bclk_q  <= 1'b0;
         lrck_q  <= 1'b1;
         dat_q   <= 1'b0;
         und_q   <= 1'b0;
         rdy_q   <= 1'b0;
         full_q  <= 1'b0;
         buf_l_q <= '0;
         buf_r_q <= '0;
         sh_l_q  <= '0;
         sh_r_q  <= '0;
      end else begin
         div_q   <= div_d;
         bit_q   <= bit_d;
         bclk_q  <= bclk_d;
         lrck_q  <= lrck_d;
         dat_q   <= dat_d;
         und_q   <= und_d;
         rdy_q   <= rdy_d;
         full_q  <= full_d;
         buf_l_q <= buf_l_d;
         buf_r_q <= buf_r_d;
         sh_l_q  <= sh_l_d;
         sh_r_q  <= sh_r_d;
      end
   end

   assign sample_ready = rdy_q;
   assign BCLK         = bclk_q;
   assign DACLRCK      = lrck_q;
   assign DACDAT       = dat_q;
   assign underrun     = und_q;

endmodule

// File: tb/tb_audio_out.sv
// tb_audio_out: directed bench for audio_out.
// Default instance plus a BCLK_DIV=2 / SLOT_BITS=17 instance.
module tb_audio_out;

   localparam int SLOT = 32;
   localparam int FR   = 256;
   localparam int SL2  = 17;
   localparam int FR2  = 68;

   logic        mclk = 1'b0;
   always #5 mclk = ~mclk;

   logic        rst_n, valid;
   logic [15:0] lin, rin;
   logic        ready, bclk, lrck, dat, und;

   logic        rst2_n, v2;
   logic [15:0] lin2, rin2;
   logic        ready2, bclk2, lrck2, dat2, und2;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          cyc2 = 0;
   bit          stream = 1'b0;
   logic [15:0] ramp = 16'h0;

   audio_out u_dut (
      .MCLK(mclk), .RESET_N(rst_n),
      .left_in(lin), .right_in(rin),
      .sample_valid(valid), .sample_ready(ready),
      .BCLK(bclk), .DACLRCK(lrck), .DACDAT(dat),
      .underrun(und)
   );

   audio_out #(.BCLK_DIV(2), .SLOT_BITS(SL2), .DATA_W(16)) u_dut2 (
      .MCLK(mclk), .RESET_N(rst2_n),
      .left_in(lin2), .right_in(rin2),
      .sample_valid(v2), .sample_ready(ready2),
      .BCLK(bclk2), .DACLRCK(lrck2), .DACDAT(dat2),
      .underrun(und2)
   );

   always @(posedge mclk) cyc  <= rst_n  ? cyc + 1  : 0;
   always @(posedge mclk) cyc2 <= rst2_n ? cyc2 + 1 : 0;

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   // Runs one 256-cycle frame of the default instance, starting just
   // after a load edge, and collects what a codec would sample.
   task automatic run_frame(
      input  int          push_at,
      input  logic [15:0] pl,
      input  logic [15:0] pr,
      output logic [31:0] ls,
      output logic [31:0] rs,
      output int          undc,
      output int          acc,
      output int          rises,
      output int          lr_bad,
      output int          dat_any
   );
      logic pb, pend;
      int   j;
      ls = '0; rs = '0;
      undc = 0; acc = 0; rises = 0; lr_bad = 0; dat_any = 0;
      pb = bclk;
      j = 0;
      for (int i = 0; i < FR; i++) begin
         if (i == push_at) begin
            lin = pl; rin = pr; valid = 1'b1;
         end
         if (und) undc++;
         if (dat) dat_any++;
         if (bclk && !pb && j < 2 * SLOT) begin
            if (lrck !== (j >= SLOT)) lr_bad++;
            if (j < SLOT) ls[SLOT-1-j] = dat;
            else          rs[2*SLOT-1-j] = dat;
            j++;
            rises++;
         end
         pb = bclk;
         pend = valid && ready;
         tick();
         if (pend) begin
            acc++;
            if (stream) begin
               ramp = ramp + 16'h1;
               lin  = ramp;
               rin  = ~ramp;
            end else begin
               valid = 1'b0;
            end
         end
      end
   endtask

   task automatic run_frame2(
      output logic [16:0] ls,
      output logic [16:0] rs,
      output int          undc,
      output int          acc,
      output int          rises,
      output int          lr_bad
   );
      logic pb, pend;
      int   j;
      ls = '0; rs = '0;
      undc = 0; acc = 0; rises = 0; lr_bad = 0;
      pb = bclk2;
      j = 0;
      for (int i = 0; i < FR2; i++) begin
         if (und2) undc++;
         if (bclk2 && !pb && j < 2 * SL2) begin
            if (lrck2 !== (j >= SL2)) lr_bad++;
            if (j < SL2) ls[SL2-1-j] = dat2;
            else         rs[2*SL2-1-j] = dat2;
            j++;
            rises++;
         end
         pb = bclk2;
         pend = v2 && ready2;
         tick();
         if (pend) begin
            acc++;
            v2 = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid = 1'b0; lin = '0; rin = '0;
      repeat (3) tick();
      n_cmp++;
      if ({bclk, lrck, dat, und, ready} !== 5'b01000) begin
         n_bad++;
         $display("FAIL rst_vals got %b want 01000",
                  {bclk, lrck, dat, und, ready});
      end
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (ready !== 1'b1 || bclk !== 1'b0) begin
         n_bad++;
         $display("FAIL rdy_after_rst got rdy=%b bclk=%b want 1 0",
                  ready, bclk);
      end
      tick();
      n_cmp++;
      if (bclk !== 1'b1) begin
         n_bad++;
         $display("FAIL bclk_rise got %b want 1", bclk);
      end
      tick();
      tick();
      n_cmp++;
      if ({bclk, lrck, und} !== 3'b001) begin
         n_bad++;
         $display("FAIL first_fall got %b want 001", {bclk, lrck, und});
      end
   endtask

   task automatic test_first_pair();
      logic [31:0] ls, rs;
      int u, a, r, lb, da;
      run_frame(0, 16'h8001, 16'h7FFE, ls, rs, u, a, r, lb, da);
      n_cmp++;
      if (ls !== 32'h0 || rs !== 32'h0 || u !== 1 || a !== 1) begin
         n_bad++;
         $display("FAIL frame0 got l=%h r=%h und=%0d acc=%0d want 0 0 1 1",
                  ls, rs, u, a);
      end
      stream = 1'b1; ramp = 16'h0;
      lin = 16'h0; rin = 16'hFFFF; valid = 1'b1;
      run_frame(-1, 16'h0, 16'h0, ls, rs, u, a, r, lb, da);
      n_cmp++;
      if (ls !== {1'b0, 16'h8001, 15'h0}) begin
         n_bad++;
         $display("FAIL f1_left got %h want %h", ls,
                  {1'b0, 16'h8001, 15'h0});
      end
      n_cmp++;
      if (rs !== {1'b0, 16'h7FFE, 15'h0}) begin
         n_bad++;
         $display("FAIL f1_right got %h want %h", rs,
                  {1'b0, 16'h7FFE, 15'h0});
      end
      n_cmp++;
      if (u !== 0 || a !== 1 || r !== 64 || lb !== 0) begin
         n_bad++;
         $display("FAIL f1_misc got und=%0d acc=%0d rises=%0d lrbad=%0d want 0 1 64 0",
                  u, a, r, lb);
      end
   endtask

   task automatic test_stream();
      logic [31:0] ls, rs;
      logic [15:0] e;
      int u, a, r, lb, da;
      for (int f = 0; f < 4; f++) begin
         e = 16'(f);
         run_frame(-1, 16'h0, 16'h0, ls, rs, u, a, r, lb, da);
         n_cmp++;
         if (ls !== {1'b0, e, 15'h0} || rs !== {1'b0, ~e, 15'h0}) begin
            n_bad++;
            $display("FAIL ramp%0d got l=%h r=%h want l=%h r=%h", f, ls, rs,
                     {1'b0, e, 15'h0}, {1'b0, ~e, 15'h0});
         end
         n_cmp++;
         if (u !== 0 || a !== 1 || lb !== 0) begin
            n_bad++;
            $display("FAIL ramp%0d_hs got und=%0d acc=%0d lrbad=%0d want 0 1 0",
                     f, u, a, lb);
         end
      end
   endtask

   task automatic test_gap();
      logic [31:0] ls, rs;
      int u, a, r, lb, da, tot;
      stream = 1'b0; valid = 1'b0;
      run_frame(-1, 16'h0, 16'h0, ls, rs, u, a, r, lb, da);
      n_cmp++;
      if (ls !== {1'b0, 16'h0004, 15'h0} || u !== 0 || a !== 0) begin
         n_bad++;
         $display("FAIL gap_last got l=%h und=%0d acc=%0d want %h 0 0",
                  ls, u, a, {1'b0, 16'h0004, 15'h0});
      end
      tot = 0;
      for (int f = 0; f < 3; f++) begin
         run_frame(-1, 16'h0, 16'h0, ls, rs, u, a, r, lb, da);
         tot += u;
         n_cmp++;
         if (u !== 1 || da !== 0 || r !== 64 || lb !== 0) begin
            n_bad++;
            $display("FAIL gap%0d got und=%0d dat=%0d rises=%0d lrbad=%0d want 1 0 64 0",
                     f, u, da, r, lb);
         end
      end
      n_cmp++;
      if (tot !== 3) begin
         n_bad++;
         $display("FAIL gap_und_total got %0d want 3", tot);
      end
   endtask

   task automatic test_coincide();
      logic [31:0] ls, rs;
      int u, a, r, lb, da;
      run_frame(255, 16'h1234, 16'hABCD, ls, rs, u, a, r, lb, da);
      n_cmp++;
      if (a !== 1 || u !== 1) begin
         n_bad++;
         $display("FAIL coin_push got acc=%0d und=%0d want 1 1", a, u);
      end
      run_frame(-1, 16'h0, 16'h0, ls, rs, u, a, r, lb, da);
      n_cmp++;
      if (u !== 1 || ls !== 32'h0 || rs !== 32'h0 || a !== 0) begin
         n_bad++;
         $display("FAIL coin_load got und=%0d l=%h r=%h acc=%0d want 1 0 0 0",
                  u, ls, rs, a);
      end
      run_frame(-1, 16'h0, 16'h0, ls, rs, u, a, r, lb, da);
      n_cmp++;
      if (ls !== {1'b0, 16'h1234, 15'h0} ||
          rs !== {1'b0, 16'hABCD, 15'h0} || u !== 0) begin
         n_bad++;
         $display("FAIL coin_next got l=%h r=%h und=%0d want %h %h 0",
                  ls, rs, u, {1'b0, 16'h1234, 15'h0},
                  {1'b0, 16'hABCD, 15'h0});
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] ls, rs;
      int u, a, r, lb, da;
      logic pend;
      run_frame(0, 16'h5555, 16'hAAAA, ls, rs, u, a, r, lb, da);
      lin = 16'h0F0F; rin = 16'hF0F0; valid = 1'b1;
      pend = valid && ready;
      tick();
      valid = 1'b0;
      n_cmp++;
      if (pend !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_push got %b want 1", pend);
      end
      repeat (39) tick();
      rst_n = 1'b0;
      tick();
      n_cmp++;
      if ({bclk, lrck, dat, und, ready} !== 5'b01000) begin
         n_bad++;
         $display("FAIL mid_rst got %b want 01000",
                  {bclk, lrck, dat, und, ready});
      end
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      n_cmp++;
      if (lrck !== 1'b1 || und !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_early got lrck=%b und=%b want 1 0", lrck, und);
      end
      tick();
      n_cmp++;
      if (lrck !== 1'b0 || und !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_fall got lrck=%b und=%b want 0 1", lrck, und);
      end
      run_frame(-1, 16'h0, 16'h0, ls, rs, u, a, r, lb, da);
      n_cmp++;
      if (u !== 1 || da !== 0) begin
         n_bad++;
         $display("FAIL mid_discard got und=%0d dat=%0d want 1 0", u, da);
      end
   endtask

   task automatic test_small();
      logic [16:0] ls, rs;
      int u, a, r, lb;
      tick();
      rst2_n = 1'b1;
      tick();
      n_cmp++;
      if (ready2 !== 1'b1 || bclk2 !== 1'b1) begin
         n_bad++;
         $display("FAIL s_rel got rdy=%b bclk=%b want 1 1", ready2, bclk2);
      end
      tick();
      n_cmp++;
      if ({bclk2, lrck2, und2} !== 3'b001) begin
         n_bad++;
         $display("FAIL s_fall got %b want 001", {bclk2, lrck2, und2});
      end
      lin2 = 16'hC3A5; rin2 = 16'h5A3C; v2 = 1'b1;
      run_frame2(ls, rs, u, a, r, lb);
      n_cmp++;
      if (ls !== 17'h0 || a !== 1 || u !== 1) begin
         n_bad++;
         $display("FAIL s_f0 got l=%h acc=%0d und=%0d want 0 1 1", ls, a, u);
      end
      run_frame2(ls, rs, u, a, r, lb);
      n_cmp++;
      if (ls !== {1'b0, 16'hC3A5} || rs !== {1'b0, 16'h5A3C}) begin
         n_bad++;
         $display("FAIL s_f1 got l=%h r=%h want %h %h", ls, rs,
                  {1'b0, 16'hC3A5}, {1'b0, 16'h5A3C});
      end
      n_cmp++;
      if (r !== 34 || lb !== 0 || u !== 0) begin
         n_bad++;
         $display("FAIL s_timing got rises=%0d lrbad=%0d und=%0d want 34 0 0",
                  r, lb, u);
      end
   endtask

   initial begin
      rst2_n = 1'b0; v2 = 1'b0; lin2 = '0; rin2 = '0;
      test_reset();
      test_first_pair();
      test_stream();
      test_gap();
      test_coincide();
      test_reset_mid();
      test_small();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
